// File: rtl/mem_addr_router.sv
// Registered load/store address decoder: splits a byte address into word address,
// offset and lane enables, tags it with a region and holds it for a per-region wait.
module mem_addr_router #(
   parameter int ADDR_W   = 32,
   parameter int N_REGION = 2,
   parameter int TAG_W    = 4,
   parameter logic [N_REGION*TAG_W-1:0] REGION_TAGS = {4'h8, 4'h0},
   parameter logic [N_REGION*4-1:0]     REGION_WAIT = {4'd2, 4'd0}
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_we,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [1:0]        out_byte_off,
   output logic [3:0]        out_byte_en,
   output logic              out_we,
   output logic [N_REGION-1:0] out_region,
   output logic              out_misaligned,
   output logic              out_unmapped
);

   typedef enum logic [1:0] {IDLE, WAIT, VALID} state_t;

   state_t              state;
   logic [3:0]          cnt;
   logic                accept;
   logic [TAG_W-1:0]    tag;
   logic [1:0]          off;
   logic [N_REGION-1:0] region_d;
   logic                found;
   logic [3:0]          region_wait;
   logic [3:0]          be_raw;
   logic                mis;
   logic [3:0]          wait_ld;

   assign req_ready = rst_n & ((state == IDLE) | ((state == VALID) & out_ready));
   assign accept    = req_valid & req_ready;
   assign tag       = req_addr[ADDR_W-1 -: TAG_W];
   assign off       = req_addr[1:0];

   // Priority match: the lowest-index region wins so out_region stays one-hot.
   always_comb begin
      region_d    = '0;
      found       = 1'b0;
      region_wait = 4'd0;
      for (int i = 0; i < N_REGION; i++) begin
         if (!found && (tag == REGION_TAGS[i*TAG_W +: TAG_W])) begin
            region_d[i] = 1'b1;
            found       = 1'b1;
            region_wait = REGION_WAIT[i*4 +: 4];
         end
      end
   end

   always_comb begin
      be_raw = 4'b0000;
      case (req_size)
         2'b00:   be_raw = 4'b0001 << off;
         2'b01:   be_raw = off[1] ? 4'b1100 : 4'b0011;
         2'b10:   be_raw = 4'b1111;
         default: be_raw = 4'b0000;
      endcase
   end

   assign mis     = ((req_size == 2'b01) && off[0]) ||
                    ((req_size == 2'b10) && (off != 2'b00)) ||
                    (req_size == 2'b11);
   // Faulting accesses are presented immediately rather than paying the device wait.
   assign wait_ld = (mis || !found) ? 4'd0 : region_wait;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         cnt            <= 4'd0;
         out_valid      <= 1'b0;
         out_addr       <= '0;
         out_byte_off   <= 2'b00;
         out_byte_en    <= 4'b0000;
         out_we         <= 1'b0;
         out_region     <= '0;
         out_misaligned <= 1'b0;
         out_unmapped   <= 1'b0;
      end else if (accept) begin
         out_addr       <= {req_addr[ADDR_W-1:2], 2'b00};
         out_byte_off   <= off;
         out_byte_en    <= mis ? 4'b0000 : be_raw;
         out_we         <= req_we;
         out_region     <= region_d;
         out_misaligned <= mis;
         out_unmapped   <= !found;
         cnt            <= wait_ld;
         if (wait_ld == 4'd0) begin
            state     <= VALID;
            out_valid <= 1'b1;
         end else begin
            state     <= WAIT;
            out_valid <= 1'b0;
         end
      end else begin
         case (state)
            IDLE: out_valid <= 1'b0;
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state     <= VALID;
                  out_valid <= 1'b1;
               end
            end
            VALID: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
